// File: rtl/keypad_pkg.sv
// Shared types, key codes and helper functions for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_HELD
    } state_e;

    localparam logic [3:0] KEY_A     = 4'd10;
    localparam logic [3:0] KEY_B     = 4'd11;
    localparam logic [3:0] KEY_C     = 4'd12;
    localparam logic [3:0] KEY_D     = 4'd13;
    localparam logic [3:0] KEY_STAR  = 4'd14;
    localparam logic [3:0] KEY_HASH  = 4'd15;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = '0;
        unique case ({row, col})
            4'd0:  code = 4'd1;
            4'd1:  code = 4'd2;
            4'd2:  code = 4'd3;
            4'd3:  code = KEY_A;
            4'd4:  code = 4'd4;
            4'd5:  code = 4'd5;
            4'd6:  code = 4'd6;
            4'd7:  code = KEY_B;
            4'd8:  code = 4'd7;
            4'd9:  code = 4'd8;
            4'd10: code = 4'd9;
            4'd11: code = KEY_C;
            4'd12: code = KEY_STAR;
            4'd13: code = 4'd0;
            4'd14: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Pattern with only bit idx low; used for both column drive and row match.
    function automatic logic [3:0] cold_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        hit = 1'b0;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = '0;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan-rate divider: one-cycle tick_o every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic resetN,
    output logic tick_o
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, row debounce, ghost rejection, one strobe per press.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe every REPEAT_TICKS while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEB_TICKS    = 16,
    parameter int REPEAT_TICKS = 500
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypress,
    output logic       rdy
);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS);

    if (SCAN_DIV < 2 || DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]    sync1_q, sync2_q;
    logic          tick;
    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [DW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    key_q, key_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .resetN (resetN),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= ROWS_IDLE;
            sync2_q <= ROWS_IDLE;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_SCAN;
            col_q     <= '0;
            row_q     <= '0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
            key_q     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            deb_cnt_q <= deb_cnt_d;
            rel_cnt_q <= rel_cnt_d;
            key_q     <= key_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        deb_cnt_d = deb_cnt_q;
        rel_cnt_d = rel_cnt_q;
        key_d     = key_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    // Two or more low rows is a ghost pattern and is treated as no key.
                    if (single_low(sync2_q)) begin
                        row_d = low_index(sync2_q);
                        if (DEB_TICKS == 1) begin
                            state_d = ST_EMIT;
                            key_d   = key_code(low_index(sync2_q), col_q);
                        end else begin
                            state_d   = ST_DEBOUNCE;
                            deb_cnt_d = DW'(1);
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (sync2_q == cold_onehot(row_q)) begin
                        if (deb_cnt_q + DW'(1) == DEB_LAST) begin
                            state_d   = ST_EMIT;
                            key_d     = key_code(row_q, col_q);
                            deb_cnt_d = '0;
                        end else begin
                            deb_cnt_d = deb_cnt_q + DW'(1);
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_d     = col_q + 2'd1;
                        deb_cnt_d = '0;
                    end
                end
            end
            ST_EMIT: begin
                state_d   = ST_HELD;
                rel_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt_d = '0;
`endif
            end
            ST_HELD: begin
                if (tick) begin
                    if (sync2_q == ROWS_IDLE) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_d = '0;
`endif
                        if (rel_cnt_q + DW'(1) == DEB_LAST) begin
                            state_d   = ST_SCAN;
                            col_d     = col_q + 2'd1;
                            rel_cnt_d = '0;
                        end else begin
                            rel_cnt_d = rel_cnt_q + DW'(1);
                        end
                    end else begin
                        rel_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        // Repeats reuse EMIT; key_q is untouched so the code is unchanged.
                        if (rep_cnt_q + RW'(1) == REP_LAST) begin
                            state_d   = ST_EMIT;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
`endif
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    assign col_out  = cold_onehot(col_q);
    assign keypress = key_q;
    assign rdy      = (state_q == ST_EMIT);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad and key-layout model.
module tb_keypad_scanner;
    localparam int SCAN_DIV     = 4;
    localparam int DEB_TICKS    = 3;
    localparam int REPEAT_TICKS = 5;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] keypress;
    logic       rdy;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int         cycle = 0;
    int         rdy_count = 0;
    int         last_rdy_cyc = 0;
    logic [3:0] last_key = '0;
    int         col_enter[4];
    int         col_changes = 0;
    int         rot_err = 0;
    int         cold_err = 0;
    logic [3:0] prev_col = 4'b1110;
    bit         prev_valid = 1'b0;

    typedef struct {
        int row;
        int col;
        int code;
    } vec_t;
    vec_t vecs[16];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .row_in   (row_in),
        .col_out  (col_out),
        .keypress (keypress),
        .rdy      (rdy)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
    end

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (rdy === 1'b1) begin
            rdy_count    <= rdy_count + 1;
            last_rdy_cyc <= cycle + 1;
            last_key     <= keypress;
        end
        if (!resetN) begin
            prev_valid <= 1'b0;
        end else begin
            if ($countones(~col_out) != 1) cold_err <= cold_err + 1;
            if (prev_valid && col_out != prev_col) begin
                col_changes <= col_changes + 1;
                if (col_out != {prev_col[2:0], prev_col[3]}) rot_err <= rot_err + 1;
            end
            if (!prev_valid || col_out != prev_col)
                for (int c = 0; c < 4; c++)
                    if (col_out[c] == 1'b0) col_enter[c] <= cycle + 1;
            prev_col   <= col_out;
            prev_valid <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int base, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (rdy_count > base) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_col(input logic [3:0] pat, input bool_eq);
        for (int i = 0; i < 64; i++) begin
            if ((col_out == pat) == bool_eq) break;
            cyc(1);
        end
    endtask

    // Reference layout read left-to-right, top-to-bottom.
    function automatic int model_code(input int r, input int c);
        string lay;
        byte   ch;
        lay = "123A456B789C*0#D";
        ch  = lay[r*4+c];
        if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
        if (ch >= "A" && ch <= "D") return int'(ch) - int'("A") + 10;
        if (ch == "*") return 14;
        return 15;
    endfunction

    function automatic int model_repeats(input int pressed_ticks);
`ifdef KEYPAD_AUTOREPEAT_EN
        return pressed_ticks / REPEAT_TICKS;
`else
        return 0 * pressed_ticks;
`endif
    endfunction

    // Press, hold hold_k ticks past the strobe, release, let release debounce finish.
    // Release lands mid-interval; synchroniser delay means one further tick still sees the key.
    task automatic press_cycle(input int r, input int c, input int hold_k, input string tag,
                               input int exp_cd);
        int base;
        bit seen;
        base = rdy_count;
        pressed = '0;
        pressed[r*4+c] = 1'b1;
        wait_rdy(base, 12*SCAN_DIV, seen);
        check({tag, "_rdy_seen"}, int'(seen), 1);
        check({tag, "_code"}, int'(last_key), exp_cd);
        cyc(hold_k*SCAN_DIV + 2);
        pressed = '0;
        cyc((DEB_TICKS + 2)*SCAN_DIV);
        check({tag, "_rdy_count"}, rdy_count - base, 1 + model_repeats(hold_k + 1));
    endtask

    task automatic ghost(input int r1, input int r2, input int c, input string tag);
        int base;
        int chg;
        base = rdy_count;
        chg  = col_changes;
        pressed = '0;
        pressed[r1*4+c] = 1'b1;
        pressed[r2*4+c] = 1'b1;
        cyc(12*SCAN_DIV);
        check({tag, "_cols_cycling"}, int'(col_changes - chg >= 11), 1);
        pressed = '0;
        cyc((DEB_TICKS + 2)*SCAN_DIV);
        check({tag, "_no_rdy"}, rdy_count - base, 0);
    endtask

    initial begin
        int  base;
        int  e0;
        bit  seen;

        vecs = '{'{0,0,1}, '{0,1,2}, '{0,2,3}, '{0,3,10},
                 '{1,0,4}, '{1,1,5}, '{1,2,6}, '{1,3,11},
                 '{2,0,7}, '{2,1,8}, '{2,2,9}, '{2,3,12},
                 '{3,0,14}, '{3,1,0}, '{3,2,15}, '{3,3,13}};

        resetN = 1'b0;
        cyc(3);
        check("reset_rdy", int'(rdy), 0);
        check("reset_keypress", int'(keypress), 0);
        check("reset_col_out", int'(col_out), 4'b1110);
        resetN = 1'b1;
        cyc(1);

        // '8' pressed before column 1 is reached; latency measured from column-1 entry.
        wait_col(4'b1110, 1'b1);
        base = rdy_count;
        pressed = '0;
        pressed[2*4+1] = 1'b1;
        wait_rdy(base, 12*SCAN_DIV, seen);
        check("key8_rdy_seen", int'(seen), 1);
        check("key8_code", int'(last_key), 8);
        check("key8_latency", last_rdy_cyc - col_enter[1], DEB_TICKS*SCAN_DIV);
        cyc(36*SCAN_DIV + 2);
        pressed = '0;
        cyc((DEB_TICKS + 2)*SCAN_DIV);
        check("key8_rdy_count", rdy_count - base, 1 + model_repeats(37));

        // '9' bouncing: low, high, then low from the third tick on.
        wait_col(4'b1011, 1'b0);
        wait_col(4'b1011, 1'b1);
        e0 = cycle;
        base = rdy_count;
        pressed = '0;
        pressed[2*4+2] = 1'b1;
        cyc(5);
        pressed = '0;
        cyc(4);
        pressed[2*4+2] = 1'b1;
        cyc(4);
        check("bounce_no_first_rdy", rdy_count - base, 0);
        wait_rdy(base, 16*SCAN_DIV, seen);
        check("bounce_rdy_seen", int'(seen), 1);
        check("bounce_code", int'(last_key), 9);
        check("bounce_col_reentered", int'(col_enter[2] > e0), 1);
        check("bounce_latency", last_rdy_cyc - col_enter[2], DEB_TICKS*SCAN_DIV);
        cyc(2);
        pressed = '0;
        cyc((DEB_TICKS + 2)*SCAN_DIV);
        check("bounce_rdy_count", rdy_count - base, 1);

        ghost(0, 2, 2, "ghost_r0r2_c2");

        // Reset pulse while '7' is held.
        base = rdy_count;
        pressed = '0;
        pressed[2*4+0] = 1'b1;
        wait_rdy(base, 12*SCAN_DIV, seen);
        check("rst7_first_rdy", int'(seen), 1);
        check("rst7_first_code", int'(last_key), 7);
        cyc(2*SCAN_DIV);
        base = rdy_count;
        resetN = 1'b0;
        cyc(2);
        check("rst7_in_reset_rdy", int'(rdy), 0);
        check("rst7_in_reset_keypress", int'(keypress), 0);
        check("rst7_in_reset_col_out", int'(col_out), 4'b1110);
        resetN = 1'b1;
        wait_rdy(base, 12*SCAN_DIV, seen);
        check("rst7_re_rdy", int'(seen), 1);
        check("rst7_re_code", int'(last_key), 7);
        cyc(2);
        pressed = '0;
        cyc((DEB_TICKS + 2)*SCAN_DIV);
        check("rst7_rdy_count", rdy_count - base, 1);

        press_cycle(3, 2, 20, "hash_hold", 15);

        for (int i = 0; i < 16; i++)
            press_cycle(vecs[i].row, vecs[i].col, 2, $sformatf("tbl%0d", i), vecs[i].code);

        for (int i = 0; i < 20; i++) begin
            int r, c, r2;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                r2 = (r + int'($urandom_range(1, 3))) % 4;
                ghost(r, r2, c, $sformatf("rnd%0d_ghost", i));
            end else begin
                press_cycle(r, c, int'($urandom_range(0, 12)), $sformatf("rnd%0d", i),
                            model_code(r, c));
            end
        end

        check("col_rotation_errors", rot_err, 0);
        check("col_one_cold_errors", cold_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per scan tick, minimum 2.
REQ-002 SHALL have parameter DEB_TICKS, default 16: consecutive identical samples required for press or release, minimum 1.
REQ-003 SHALL have parameter REPEAT_TICKS, default 500: auto-repeat period in ticks; used only with KEYPAD_AUTOREPEAT_EN.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port resetN, input, 1 bit: reset. Reset is asynchronous and active-low.
REQ-006 SHALL have port row_in, input, 4 bits: keypad rows, active-low (pulled up), asynchronous to clk.
REQ-007 SHALL have port col_out, output, 4 bits: keypad column drive, one-cold; bit c low means column c is driven.
REQ-008 SHALL have port keypress, output, 4 bits: code of the last accepted key.
REQ-009 SHALL have port rdy, output, 1 bit: one-cycle strobe meaning keypress is new and valid.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL generate a one-cycle tick every SCAN_DIV cycles from a free-running counter, cleared by reset.
REQ-012 SHALL map (row,col) to codes as follows:
- row0 = 1,2,3,A -> 1,2,3,10
- row1 = 4,5,6,B -> 4,5,6,11
- row2 = 7,8,9,C -> 7,8,9,12
- row3 = *,0,#,D -> 14,0,15,13
REQ-013 SHALL implement the states SCAN, DEBOUNCE, EMIT and HELD.
REQ-014 SCAN: on each tick, SHALL sample rows for the current column.
- Exactly one row low: capture row and go to DEBOUNCE (count=1), keeping the column.
- Otherwise: advance column, wrapping 3->0.
REQ-015 Two or more rows low in SCAN SHALL count as no key (ghost rejection); the column advances.
REQ-016 DEBOUNCE: on each tick, the same single-row pattern SHALL increment count.
- count reaching DEB_TICKS: go to EMIT.
- Any other pattern: go to SCAN and advance column.
REQ-017 DEB_TICKS=1 SHALL go from SCAN directly to EMIT on the capture tick.
REQ-018 EMIT SHALL last exactly one cycle: rdy=1 and keypress=new code in that same cycle, then go to HELD.
REQ-019 HELD: SHALL keep the column driven. On each tick, rows all high increment a release count; any low row clears it.
REQ-020 In HELD, release count reaching DEB_TICKS SHALL go to SCAN and advance the column. No rdy is issued on release.
REQ-021 In HELD, a different key in the same column SHALL be ignored until release.
REQ-022 keypress SHALL hold its value between strobes. rdy SHALL be 0 in every state except EMIT.
REQ-023 Latency from a stable press in the column being scanned SHALL be DEB_TICKS ticks plus 1 cycle to rdy.

Reset
REQ-024 While resetN=0, outputs SHALL be: rdy=0, keypress=0, col_out=4'b1110.
REQ-025 While resetN=0, internal state SHALL be: state=SCAN, column=0, all counters=0, synchronizer=4'b1111.
REQ-026 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no rdy. After release, a still-held key is re-debounced and emitted once.

Configuration
REQ-027 With macro KEYPAD_AUTOREPEAT_EN defined, HELD SHALL count ticks while the key stays pressed.
- Each time the count reaches REPEAT_TICKS: one-cycle rdy with the unchanged code, then count restarts.
- Release SHALL stop repeats.
REQ-028 Without KEYPAD_AUTOREPEAT_EN, SHALL issue exactly one rdy per press, and the repeat counter SHALL be absent.

Structure
REQ-029 Package keypad_pkg SHALL hold: the state enum, key code constants (KEY_STAR=14, KEY_HASH=15, KEY_A..KEY_D=10..13), and the (row,col)->code map function.
REQ-030 Sub-module keypad_tick_gen SHALL contain the SCAN_DIV tick counter; all other logic SHALL stay in keypad_scanner.

Verification (SCAN_DIV=4, DEB_TICKS=3, REPEAT_TICKS=5)
REQ-031 Press '8' (row2, col1) held 40 ticks -> exactly one rdy, keypress=8, 3 ticks + 1 cycle after col_out=4'b1101 first samples it.
REQ-032 Press '9' bouncing (low, high, low, low, low per tick) -> no rdy on the first attempt; single rdy with keypress=9 after 3 stable samples.
REQ-033 Rows 0 and 2 low together in col 2 -> no rdy; col_out keeps cycling 1110,1101,1011,0111.
REQ-034 Hold '7', pulse resetN low in HELD for 2 cycles -> outputs reset per REQ-024; one new rdy with keypress=7 after re-debounce.
REQ-035 With KEYPAD_AUTOREPEAT_EN, hold '#' 20 ticks past the first rdy -> 4 further rdy strobes, keypress=15; none after release.
